// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch controller: state encoding and BCD digit limits.
package stopwatch_pkg;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LAP   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StRun   = ST_RUN,
        StLap   = ST_LAP,
        StPause = ST_PAUSE
    } state_e;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 6;

    // Per-digit maximum, packed with hundredths ones in [3:0] up to minute tens in [23:20]
    localparam logic [DIGIT_W*NUM_DIGITS-1:0] DIGIT_MAX_VEC = {
        4'd5,  // minute tens
        4'd9,  // minute ones
        4'd5,  // second tens
        4'd9,  // second ones
        4'd9,  // hundredths tens
        4'd9   // hundredths ones
    };

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the cascaded count chain; wraps to zero after MAX.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               tc
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    // Terminal count is combinational so the carry reaches upper digits on the same edge
    assign tc = (q_q == MAX);
    assign q  = q_q;

    // Next count: clear wins, otherwise advance and wrap at MAX
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = tc ? '0 : q_q + 1'b1;
        end
    end

    // Digit register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: key synchronisers, start/pause/lap/clear FSM, centisecond
// prescaler and the six-digit MM:SS.hh BCD chain with a frozen lap display.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        start_n,
    input  logic        lap_n,
    input  logic        clear_n,
    output logic [23:0] digits,
    output logic        tick,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    // Key bit order: [2] clear, [1] lap, [0] start
    logic [2:0] key_raw;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] prev_q;
    logic [2:0] press;

    logic ev_clear;
    logic ev_start;
    logic ev_lap;

    state_e state_q;
    logic   counting;
    logic   clr_digits;

    logic [PW-1:0] presc_q;

    logic [DIGIT_W*NUM_DIGITS-1:0] live;
    logic [DIGIT_W*NUM_DIGITS-1:0] lap_q;
    logic [DIGIT_W*NUM_DIGITS-1:0] disp_q;
    logic [NUM_DIGITS-1:0]         tc;
    logic [NUM_DIGITS:0]           carry;

    assign key_raw = {clear_n, lap_n, start_n};

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press = prev_q & ~sync2_q;

    // Priority clear > start > lap; losers in the same cycle are dropped
    assign ev_clear = press[2];
    assign ev_start = press[0] & ~press[2];
    assign ev_lap   = press[1] & ~press[2] & ~press[0];

    assign counting   = (state_q == StRun) || (state_q == StLap);
    assign clr_digits = (state_q == StPause) && ev_clear;
    assign tick       = counting && (presc_q == PMAX);

    // Controller FSM; the lap latch captures live digits on the RUN -> LAP edge
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            lap_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ev_start) state_q <= StRun;
                end
                StRun: begin
                    if (ev_start) begin
                        state_q <= StPause;
                    end else if (ev_lap) begin
                        state_q <= StLap;
                        lap_q   <= live;
                    end
                end
                StLap: begin
                    if (ev_start) begin
                        state_q <= StPause;
                    end else if (ev_lap) begin
                        state_q <= StRun;
                    end
                end
                StPause: begin
                    if (ev_clear) begin
                        state_q <= StIdle;
                    end else if (ev_start) begin
                        state_q <= StRun;
                    end
                end
            endcase
        end
    end

    // Prescaler: runs while counting, holds in PAUSE so a resume keeps the partial interval
    always_ff @(posedge Clock) begin
        if (Reset || (state_q == StIdle) || clr_digits) begin
            presc_q <= '0;
        end else if (counting) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    // Ripple-free carry: digit i advances when tick and all lower digits are at max
    assign carry[0] = tick;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_counter #(
            .MAX(DIGIT_MAX_VEC[DIGIT_W*i +: DIGIT_W])
        ) u_digit (
            .Clock(Clock),
            .Reset(Reset),
            .clr  (clr_digits),
            .en   (carry[i]),
            .q    (live[DIGIT_W*i +: DIGIT_W]),
            .tc   (tc[i])
        );
        assign carry[i+1] = carry[i] & tc[i];
    end

    assign overflow = carry[NUM_DIGITS];

    // Display register: lap latch while in LAP, live count otherwise
    always_ff @(posedge Clock) begin
        if (Reset) begin
            disp_q <= '0;
        end else begin
            disp_q <= (state_q == StLap) ? lap_q : live;
        end
    end

    assign digits     = disp_q;
    assign running    = counting;
    assign lap_active = (state_q == StLap);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_HZ=1000, TICK_HZ=100 (DIV=10).
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        start_n;
    logic        lap_n;
    logic        clear_n;
    logic [23:0] digits;
    logic        tick;
    logic        running;
    logic        lap_active;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    stopwatch_ctrl #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .start_n   (start_n),
        .lap_n     (lap_n),
        .clear_n   (clear_n),
        .digits    (digits),
        .tick      (tick),
        .running   (running),
        .lap_active(lap_active),
        .overflow  (overflow)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        Reset   = 1'b1;
        start_n = 1'b1;
        lap_n   = 1'b1;
        clear_n = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Overwrite the live count between ticks
    task automatic preload(input logic [23:0] v);
        force dut.g_digit[0].u_digit.q_q = v[3:0];
        force dut.g_digit[1].u_digit.q_q = v[7:4];
        force dut.g_digit[2].u_digit.q_q = v[11:8];
        force dut.g_digit[3].u_digit.q_q = v[15:12];
        force dut.g_digit[4].u_digit.q_q = v[19:16];
        force dut.g_digit[5].u_digit.q_q = v[23:20];
        @(negedge Clock);
        release dut.g_digit[0].u_digit.q_q;
        release dut.g_digit[1].u_digit.q_q;
        release dut.g_digit[2].u_digit.q_q;
        release dut.g_digit[3].u_digit.q_q;
        release dut.g_digit[4].u_digit.q_q;
        release dut.g_digit[5].u_digit.q_q;
    endtask

    // Bounded wait for the next tick pulse, sampled on negedges
    task automatic wait_tick(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: tick seen=0 want=1 within 20 cycles", name);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total += 5;
        if (digits !== 24'h0) begin bad++; $display("FAIL reset_digits: got %h want 000000", digits); end
        if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", running); end
        if (lap_active !== 1'b0) begin bad++; $display("FAIL reset_lap: got %b want 0", lap_active); end
        if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_run_1s();
        int k = 0;
        int ticks = 0;
        start_n = 1'b0;
        while (!running && k < 10) begin
            @(negedge Clock);
            k++;
        end
        start_n = 1'b1;
        total++;
        if (k !== 3) begin bad++; $display("FAIL start_latency: got %0d want 3", k); end
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clock);
            if (tick) ticks++;
        end
        @(negedge Clock);
        total += 3;
        if (ticks !== 100) begin bad++; $display("FAIL tick_count: got %0d want 100", ticks); end
        if (digits !== 24'h000100) begin bad++; $display("FAIL run_1s_digits: got %h want 000100", digits); end
        if (running !== 1'b1) begin bad++; $display("FAIL run_1s_running: got %b want 1", running); end
    endtask

    task automatic test_sec_to_min();
        wait_tick("sec_sync");
        @(negedge Clock);
        preload(24'h005999);
        wait_tick("sec_tick");
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL min_carry_overflow: got %b want 0", overflow); end
        repeat (2) @(negedge Clock);
        total++;
        if (digits !== 24'h010000) begin bad++; $display("FAIL min_carry_digits: got %h want 010000", digits); end
    endtask

    task automatic test_overflow();
        int extra = 0;
        wait_tick("ovf_sync");
        @(negedge Clock);
        preload(24'h595999);
        wait_tick("ovf_tick");
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
        for (int k = 1; k <= 15; k++) begin
            @(negedge Clock);
            if (overflow) extra++;
            if (k == 2) begin
                total += 2;
                if (digits !== 24'h000000) begin bad++; $display("FAIL ovf_digits: got %h want 000000", digits); end
                if (dut.state_q !== ST_RUN) begin bad++; $display("FAIL ovf_state: got %0d want %0d", dut.state_q, ST_RUN); end
            end
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL ovf_single_cycle: extra pulses got %0d want 0", extra); end
    endtask

    task automatic test_lap();
        int k = 0;
        do_reset();
        start_n = 1'b0;
        while (!running && k < 10) begin
            @(negedge Clock);
            k++;
        end
        start_n = 1'b1;
        repeat (502) @(negedge Clock);
        lap_n = 1'b0;
        repeat (3) @(negedge Clock);
        lap_n = 1'b1;
        total += 2;
        if (lap_active !== 1'b1) begin bad++; $display("FAIL lap_enter: got %b want 1", lap_active); end
        if (digits !== 24'h000050) begin bad++; $display("FAIL lap_capture: got %h want 000050", digits); end
        repeat (500) @(negedge Clock);
        total += 2;
        if (digits !== 24'h000050) begin bad++; $display("FAIL lap_frozen: got %h want 000050", digits); end
        if (dut.live !== 24'h000100) begin bad++; $display("FAIL lap_live: got %h want 000100", dut.live); end
        lap_n = 1'b0;
        repeat (3) @(negedge Clock);
        lap_n = 1'b1;
        total++;
        if (lap_active !== 1'b0) begin bad++; $display("FAIL lap_exit: got %b want 0", lap_active); end
        @(negedge Clock);
        total++;
        if (digits !== 24'h000100) begin bad++; $display("FAIL lap_release_digits: got %h want 000100", digits); end
    endtask

    task automatic test_pause_clear();
        int k = 0;
        int ticks = 0;
        do_reset();
        start_n = 1'b0;
        while (!running && k < 10) begin
            @(negedge Clock);
            k++;
        end
        start_n = 1'b1;
        // Pause event lands on the same edge as the 10th tick
        repeat (97) @(negedge Clock);
        start_n = 1'b0;
        repeat (4) @(negedge Clock);
        total += 2;
        if (running !== 1'b0) begin bad++; $display("FAIL pause_running: got %b want 0", running); end
        if (digits !== 24'h000010) begin bad++; $display("FAIL pause_tick_coincide: got %h want 000010", digits); end
        repeat (2) @(negedge Clock);
        start_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (tick) ticks++;
        end
        total += 3;
        if (ticks !== 0) begin bad++; $display("FAIL pause_ticks: got %0d want 0", ticks); end
        if (digits !== 24'h000010) begin bad++; $display("FAIL pause_hold: got %h want 000010", digits); end
        if (running !== 1'b0) begin bad++; $display("FAIL pause_hold_key: running got %b want 0", running); end
        clear_n = 1'b0;
        repeat (4) @(negedge Clock);
        clear_n = 1'b1;
        total += 2;
        if (digits !== 24'h000000) begin bad++; $display("FAIL clear_digits: got %h want 000000", digits); end
        if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL clear_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        // Clear while running must be ignored
        start_n = 1'b0;
        repeat (3) @(negedge Clock);
        start_n = 1'b1;
        repeat (17) @(negedge Clock);
        clear_n = 1'b0;
        repeat (10) @(negedge Clock);
        clear_n = 1'b1;
        total += 2;
        if (running !== 1'b1) begin bad++; $display("FAIL clear_in_run_running: got %b want 1", running); end
        if (digits !== 24'h000002) begin bad++; $display("FAIL clear_in_run_digits: got %h want 000002", digits); end
    endtask

    task automatic test_simultaneous();
        start_n = 1'b0;
        repeat (4) @(negedge Clock);
        start_n = 1'b1;
        repeat (4) @(negedge Clock);
        total += 2;
        if (running !== 1'b0) begin bad++; $display("FAIL simul_pre_pause: got %b want 0", running); end
        if (digits !== 24'h000003) begin bad++; $display("FAIL simul_pre_digits: got %h want 000003", digits); end
        start_n = 1'b0;
        clear_n = 1'b0;
        repeat (4) @(negedge Clock);
        start_n = 1'b1;
        clear_n = 1'b1;
        repeat (2) @(negedge Clock);
        total += 3;
        if (running !== 1'b0) begin bad++; $display("FAIL simul_running: got %b want 0", running); end
        if (digits !== 24'h000000) begin bad++; $display("FAIL simul_digits: got %h want 000000", digits); end
        if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL simul_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_reset_mid_run();
        start_n = 1'b0;
        repeat (3) @(negedge Clock);
        start_n = 1'b1;
        repeat (50) @(negedge Clock);
        total += 2;
        if (running !== 1'b1) begin bad++; $display("FAIL midrun_pre_running: got %b want 1", running); end
        if (digits !== 24'h000004) begin bad++; $display("FAIL midrun_pre_digits: got %h want 000004", digits); end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        total += 4;
        if (digits !== 24'h000000) begin bad++; $display("FAIL midrun_digits: got %h want 000000", digits); end
        if (running !== 1'b0) begin bad++; $display("FAIL midrun_running: got %b want 0", running); end
        if (lap_active !== 1'b0) begin bad++; $display("FAIL midrun_lap: got %b want 0", lap_active); end
        if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL midrun_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    endtask

    initial begin
        test_reset();
        test_run_1s();
        test_sec_to_min();
        test_overflow();
        test_lap();
        test_pause_clear();
        test_simultaneous();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the lab stopwatch's cascaded digit counters: divides Clock into a centisecond tick, runs a start/pause/lap/clear state machine from the board keys, and drives the six-digit MM:SS.hh BCD count chain.
- Sits between the KEY inputs and the HEX decoders, replacing ad-hoc hold/enable/rollover wiring with one registered controller.
- Provides a frozen lap display while counting continues underneath.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 100, count rate; the prescaler divisor is DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2.

Ports:
- Clock  input  1  system clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- start_n  input  1  KEY, active-low, asynchronous to Clock; start/pause.
- lap_n  input  1  KEY, active-low; lap freeze/release.
- clear_n  input  1  KEY, active-low; clear while paused.
- digits  output  24  displayed BCD digits: [23:20] min tens, [19:16] min ones, [15:12] sec tens, [11:8] sec ones, [7:4] hundredths tens, [3:0] hundredths ones.
- tick  output  1  one-cycle count-enable pulse.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP.
- overflow  output  1  one-cycle pulse on wrap from 59:59.99.

Behaviour:
- Reset (synchronous, active-high) has priority over everything:
  - state = IDLE; prescaler, all digits and the lap latch = 0.
  - tick, running, lap_active and overflow = 0.
  - Synchronizer flops are set to 1 (keys released).
  - Reset mid-count returns to IDLE with all counts zero on the next edge.
- Key inputs:
  - Each key passes through a 2-flop synchronizer, then a falling-edge detector (previous 1, current 0).
  - This yields a one-cycle press event. Press-to-FSM latency is 3 cycles.
  - Holding a key produces exactly one event.
- Event priority when several occur in the same cycle: clear > start > lap. Lower-priority events in that cycle are discarded.
- FSM states are IDLE, RUN, LAP and PAUSE. Transitions:
  - IDLE + start -> RUN. Lap and clear are ignored.
  - RUN + start -> PAUSE.
  - RUN + lap -> LAP, capturing the live digits into the lap latch on the same edge.
  - RUN + clear: ignored.
  - LAP + lap -> RUN; the display returns to live digits.
  - LAP + start -> PAUSE; the display shows live digits.
  - LAP + clear: ignored.
  - PAUSE + start -> RUN, resuming from the held count.
  - PAUSE + clear -> IDLE; all digits = 0.
  - PAUSE + lap: ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUN or LAP.
  - tick = 1 for exactly the cycle in which prescaler == DIV-1 and the state is RUN or LAP; the prescaler then wraps to 0.
  - Leaving RUN/LAP holds the prescaler value; resuming continues the partial interval.
  - IDLE forces the prescaler to 0.
- Digit chain, advanced on tick:
  - Digit maximums are 9,9,9,5,9,5, listed from hundredths ones up to minute tens.
  - Digit i increments when tick is high and every lower digit is at its maximum. A digit at its maximum wraps to 0 on the same edge.
  - Carry is combinational, so there is no early-by-one rollover flag.
  - At 59:59.99 a tick wraps every digit to 0 and pulses overflow for that cycle; counting continues.
- Display and status outputs:
  - digits = lap latch in LAP, live digits otherwise. Registered output, updating 1 cycle after the count edge.
  - running and lap_active are decoded from the registered state, with no extra latency.
- A tick coinciding with a start event that pauses the count: the tick still advances the count on that edge, because the transition and the count are evaluated from the same pre-edge state.

Decomposition:
- Package stopwatch_pkg holds:
  - the state encoding (2-bit localparams for IDLE, RUN, LAP, PAUSE);
  - the digit maximum constants;
  - the digit field width (4).
- One sub-module, bcd_digit_counter, parameterised by MAX:
  - Inputs: Clock, Reset, clr, en.
  - Outputs: q[3:0] and tc, where tc = (q == MAX) combinational.
  - Instantiated 6 times, with each en gated by tick AND all lower tc.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so DIV=10):
- Reset, press start, wait 1000 cycles -> digits = 00:01.00, tick seen 100 times, running = 1.
- Preload the count to 00:59.99 (hierarchical force) in RUN, then one tick -> digits = 01:00.00 on the same edge chain, overflow stays 0.
- Preload to 59:59.99, then one tick -> digits = 00:00.00, overflow is a single-cycle pulse, state stays RUN.
- RUN at 00:00.50, press lap -> digits frozen at 00:00.50 with lap_active = 1. After 500 cycles the internal count is 00:01.00. Press lap again -> digits = live value, lap_active = 0.
- Start, then start again (PAUSE) -> no ticks for 200 cycles and the count is held. Clear -> IDLE with digits = 0. Clear pressed during RUN -> no effect.
- start and clear asserted in the same cycle while in PAUSE -> IDLE (clear wins). Reset asserted mid-RUN -> next edge has digits = 0, running = 0, state IDLE.
